// File: rtl/axi_gpio_pkg.sv
// Register map, response codes and byte-strobe helpers for the AXI4-Lite GPIO/IRQ peripheral.
package axi_gpio_pkg;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_IRQ_EN   = 8'h04;
    localparam logic [7:0] ADDR_IRQ_STAT = 8'h08;
    localparam logic [7:0] ADDR_IN_DATA  = 8'h0C;
    localparam logic [7:0] ADDR_EDGE_SEL = 8'h10;
    localparam logic [7:0] ADDR_OUT_BASE = 8'h20;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) m[8*b +: 8] = 8'hFF;
        end
        return m;
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        m = strb_mask(strb);
        return (old_val & ~m) | (wdata & m);
    endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchroniser per GPIO bit followed by a polarity-selectable single-cycle edge pulse.
module gpio_in_sync #(
    parameter int NUM_IN = 8
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [NUM_IN-1:0] gpio_in,
    input  logic [NUM_IN-1:0] edge_sel,
    output logic [NUM_IN-1:0] in_sync,
    output logic [NUM_IN-1:0] in_evt
);

    logic [NUM_IN-1:0] gpio_p0;
    logic [NUM_IN-1:0] gpio_p1;
    logic [NUM_IN-1:0] gpio_p2;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            gpio_p0 <= '0;
            gpio_p1 <= '0;
            gpio_p2 <= '0;
        end else begin
            gpio_p0 <= gpio_in;
            gpio_p1 <= gpio_p0;
            gpio_p2 <= gpio_p1;
        end
    end

    // An event needs a real transition; the new level must match the selected polarity,
    // so rewriting edge_sel alone can never fire.
    assign in_sync = gpio_p1;
    assign in_evt  = (gpio_p1 ^ gpio_p2) & ~(gpio_p1 ^ edge_sel);

endmodule

// File: rtl/axi_gpio_irq_ctrl.sv
// AXI4-Lite slave: output registers, synchronised GPIO inputs with edge interrupts,
// enable mask, W1C status and a single registered level IRQ.
module axi_gpio_irq_ctrl
    import axi_gpio_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_OUT = 2,
    parameter int OUT_W   = 8,
    parameter int NUM_IN  = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [ADDR_W-1:0]        S_AWADDR,
    input  logic                     S_AWVALID,
    output logic                     S_AWREADY,
    input  logic [DATA_W-1:0]        S_WDATA,
    input  logic [3:0]               S_WSTRB,
    input  logic                     S_WVALID,
    output logic                     S_WREADY,
    output logic [1:0]               S_BRESP,
    output logic                     S_BVALID,
    input  logic                     S_BREADY,
    input  logic [ADDR_W-1:0]        S_ARADDR,
    input  logic                     S_ARVALID,
    output logic                     S_ARREADY,
    output logic [DATA_W-1:0]        S_RDATA,
    output logic [1:0]               S_RRESP,
    output logic                     S_RVALID,
    input  logic                     S_RREADY,
    input  logic [NUM_IN-1:0]        GPIO_IN,
    output logic [NUM_OUT*OUT_W-1:0] GPIO_OUT,
    output logic                     IRQ_OUT
);

    logic              gie;
    logic [NUM_IN-1:0] irq_en;
    logic [NUM_IN-1:0] irq_stat;
    logic [NUM_IN-1:0] edge_sel;
    logic [NUM_IN-1:0] in_sync;
    logic [NUM_IN-1:0] in_evt;
    logic [NUM_IN-1:0] stat_clr;
    logic [OUT_W-1:0]  out_reg [NUM_OUT];
    logic              irq_q;

    logic              bvalid;
    logic [1:0]        bresp;
    logic              rvalid;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;

    logic              wr_en;
    logic              wr_ok;
    logic [7:0]        wr_off;
    logic [NUM_OUT-1:0] wr_out_sel;
    logic              rd_en;
    logic              rd_ok;
    logic [7:0]        rd_off;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_addr_bits;

    gpio_in_sync #(.NUM_IN(NUM_IN)) u_in_sync (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .gpio_in  (GPIO_IN),
        .edge_sel (edge_sel),
        .in_sync  (in_sync),
        .in_evt   (in_evt)
    );

    assign unused_addr_bits = ^{S_AWADDR[ADDR_W-1:8], S_AWADDR[1:0],
                                S_ARADDR[ADDR_W-1:8], S_ARADDR[1:0]};

    // Both AW and W must be present together; no skid buffering.
    assign wr_en     = ARESETn & S_AWVALID & S_WVALID & ~bvalid;
    assign S_AWREADY = wr_en;
    assign S_WREADY  = wr_en;
    assign wr_off    = {S_AWADDR[7:2], 2'b00};

    always_comb begin
        wr_out_sel = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            wr_out_sel[i] = (wr_off == ADDR_OUT_BASE + 8'(4*i));
        end
    end

    assign wr_ok = (wr_off inside {ADDR_CTRL, ADDR_IRQ_EN, ADDR_IRQ_STAT, ADDR_IN_DATA, ADDR_EDGE_SEL})
                 | (|wr_out_sel);

    assign stat_clr = (wr_en && wr_off == ADDR_IRQ_STAT)
                    ? NUM_IN'(S_WDATA & strb_mask(S_WSTRB)) : '0;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            gie      <= 1'b0;
            irq_en   <= '0;
            edge_sel <= '0;
            irq_stat <= '0;
            irq_q    <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            for (int i = 0; i < NUM_OUT; i++) out_reg[i] <= '0;
        end else begin
            // New events take priority over a simultaneous W1C of the same bit.
            irq_stat <= (irq_stat & ~stat_clr) | in_evt;
            irq_q    <= gie & (|(irq_stat & irq_en));
            if (S_BREADY) bvalid <= 1'b0;
            if (wr_en) begin
                bvalid <= 1'b1;
                bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_off == ADDR_CTRL && S_WSTRB[0]) gie <= S_WDATA[0];
                if (wr_off == ADDR_IRQ_EN)
                    irq_en <= NUM_IN'(strb_merge(32'(irq_en), S_WDATA, S_WSTRB));
                if (wr_off == ADDR_EDGE_SEL)
                    edge_sel <= NUM_IN'(strb_merge(32'(edge_sel), S_WDATA, S_WSTRB));
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (wr_out_sel[i])
                        out_reg[i] <= OUT_W'(strb_merge(32'(out_reg[i]), S_WDATA, S_WSTRB));
                end
            end
        end
    end

    assign rd_en     = ARESETn & S_ARVALID & ~rvalid;
    assign S_ARREADY = rd_en;
    assign rd_off    = {S_ARADDR[7:2], 2'b00};

    always_comb begin
        rd_mux = '0;
        rd_ok  = 1'b1;
        case (rd_off)
            ADDR_CTRL:     rd_mux = {31'd0, gie};
            ADDR_IRQ_EN:   rd_mux = 32'(irq_en);
            ADDR_IRQ_STAT: rd_mux = 32'(irq_stat);
            ADDR_IN_DATA:  rd_mux = 32'(in_sync);
            ADDR_EDGE_SEL: rd_mux = 32'(edge_sel);
            default: begin
                rd_ok = 1'b0;
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (rd_off == ADDR_OUT_BASE + 8'(4*i)) begin
                        rd_mux = 32'(out_reg[i]);
                        rd_ok  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rvalid <= 1'b0;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else begin
            if (S_RREADY) rvalid <= 1'b0;
            if (rd_en) begin
                rvalid <= 1'b1;
                rdata  <= rd_mux;
                rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign GPIO_OUT[g*OUT_W +: OUT_W] = out_reg[g];
    end

    assign S_BVALID = bvalid;
    assign S_BRESP  = bresp;
    assign S_RVALID = rvalid;
    assign S_RRESP  = rresp;
    assign S_RDATA  = rdata;
    assign IRQ_OUT  = irq_q;

endmodule

// File: tb/tb_axi_gpio_irq_ctrl.sv
// Self-checking bench for axi_gpio_irq_ctrl against a register-level reference model.
module tb_axi_gpio_irq_ctrl;

    localparam int NUM_OUT = 2;
    localparam int OUT_W   = 16;
    localparam int NUM_IN  = 8;

    logic        ACLK;
    logic        ARESETn;
    logic [31:0] S_AWADDR;
    logic        S_AWVALID;
    logic        S_AWREADY;
    logic [31:0] S_WDATA;
    logic [3:0]  S_WSTRB;
    logic        S_WVALID;
    logic        S_WREADY;
    logic [1:0]  S_BRESP;
    logic        S_BVALID;
    logic        S_BREADY;
    logic [31:0] S_ARADDR;
    logic        S_ARVALID;
    logic        S_ARREADY;
    logic [31:0] S_RDATA;
    logic [1:0]  S_RRESP;
    logic        S_RVALID;
    logic        S_RREADY;
    logic [7:0]  GPIO_IN;
    logic [31:0] GPIO_OUT;
    logic        IRQ_OUT;

    int checks = 0;
    int errors = 0;

    logic        m_gie;
    logic [7:0]  m_en, m_stat, m_edge, m_in;
    logic [15:0] m_out [2];

    logic [7:0] offs [11] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h24,
                              8'h28, 8'h14, 8'h40, 8'hFC};

    axi_gpio_irq_ctrl #(
        .ADDR_W(32), .DATA_W(32), .NUM_OUT(NUM_OUT), .OUT_W(OUT_W), .NUM_IN(NUM_IN)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .IRQ_OUT(IRQ_OUT)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: register contents at the level of the memory map.
    function automatic logic [31:0] bmask(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic void model_reset();
        m_gie = 1'b0; m_en = '0; m_stat = '0; m_edge = '0; m_in = '0;
        m_out[0] = '0; m_out[1] = '0;
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] m, v;
        logic [7:0]  off;
        m   = bmask(s);
        off = {a[7:2], 2'b00};
        case (off)
            8'h00: begin v = ({31'd0, m_gie} & ~m) | (d & m); m_gie = v[0]; end
            8'h04: begin v = ({24'd0, m_en} & ~m) | (d & m); m_en = v[7:0]; end
            8'h08: begin v = d & m; m_stat = m_stat & ~v[7:0]; end
            8'h0C: ;
            8'h10: begin v = ({24'd0, m_edge} & ~m) | (d & m); m_edge = v[7:0]; end
            8'h20, 8'h24: begin
                v = ({16'd0, m_out[off[2]]} & ~m) | (d & m);
                m_out[off[2]] = v[15:0];
            end
            default: return 2'b10;
        endcase
        return 2'b00;
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] a);
        logic [7:0] off;
        off = {a[7:2], 2'b00};
        case (off)
            8'h00: return {2'b00, 31'd0, m_gie};
            8'h04: return {2'b00, 24'd0, m_en};
            8'h08: return {2'b00, 24'd0, m_stat};
            8'h0C: return {2'b00, 24'd0, m_in};
            8'h10: return {2'b00, 24'd0, m_edge};
            8'h20: return {2'b00, 16'd0, m_out[0]};
            8'h24: return {2'b00, 16'd0, m_out[1]};
            default: return {2'b10, 32'd0};
        endcase
    endfunction

    function automatic logic exp_irq();
        return m_gie & (|(m_stat & m_en));
    endfunction

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n = 0;
        S_AWADDR = a; S_WDATA = d; S_WSTRB = s; S_AWVALID = 1'b1; S_WVALID = 1'b1;
        #1;
        while (!(S_AWREADY && S_WREADY) && n < 16) begin @(posedge ACLK); #1; n++; end
        @(posedge ACLK); #1;
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        while (!S_BVALID && n < 16) begin @(posedge ACLK); #1; n++; end
        check("wr_handshake_in_time", n < 16, 1'b1);
        resp = S_BRESP;
        @(posedge ACLK); #1;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        S_ARADDR = a; S_ARVALID = 1'b1;
        #1;
        while (!S_ARREADY && n < 16) begin @(posedge ACLK); #1; n++; end
        @(posedge ACLK); #1;
        S_ARVALID = 1'b0;
        while (!S_RVALID && n < 16) begin @(posedge ACLK); #1; n++; end
        check("rd_handshake_in_time", n < 16, 1'b1);
        d = S_RDATA; resp = S_RRESP;
        @(posedge ACLK); #1;
    endtask

    task automatic wr_chk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
        logic [1:0] er;
        er = model_write(a, d, s);
        axi_write(a, d, s, resp);
        check("bresp", resp, er);
        check("gpio_out", GPIO_OUT, {m_out[1], m_out[0]});
        check("irq_out", IRQ_OUT, exp_irq());
    endtask

    task automatic rd_chk(input logic [31:0] a, output logic [31:0] d);
        logic [33:0] e;
        logic [1:0]  r;
        e = model_read(a);
        axi_read(a, d, r);
        check("rdata", d, e[31:0]);
        check("rresp", r, e[33:32]);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd, r, a, hd;
        logic [7:0]  nw, ev;

        ARESETn = 1'b0;
        S_AWADDR = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0;
        S_BREADY = 1'b1; S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b1; GPIO_IN = '0;
        model_reset();
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_bvalid", S_BVALID, 1'b0);
        check("rst_rvalid", S_RVALID, 1'b0);
        check("rst_bresp", S_BRESP, 2'b00);
        check("rst_rresp", S_RRESP, 2'b00);
        check("rst_rdata", S_RDATA, 32'h0);
        check("rst_gpio_out", GPIO_OUT, 32'h0);
        check("rst_irq", IRQ_OUT, 1'b0);
        check("rst_arready", S_ARREADY, 1'b0);
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // Directed output-register accesses
        wr_chk(32'h20, 32'hA5, 4'hF, resp);
        check("out0_bresp", resp, 2'b00);
        check("out0_gpio", GPIO_OUT[7:0], 8'hA5);
        rd_chk(32'h20, rd);
        check("out0_read", rd, 32'h0000_00A5);
        wr_chk(32'h24, 32'h1234, 4'h2, resp);
        check("out1_strb", GPIO_OUT[31:16], 16'h1200);

        // Unmapped address
        wr_chk(32'h40, 32'hFFFF_FFFF, 4'hF, resp);
        check("unmapped_bresp", resp, 2'b10);
        check("unmapped_no_change", GPIO_OUT, 32'h1200_00A5);
        rd_chk(32'h40, rd);
        check("unmapped_rdata", rd, 32'h0);

        // Randomized register traffic with static inputs
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            a = {r[31:8], offs[$urandom_range(0, 10)] & 8'hFC};
            a[1:0] = r[1:0];
            if ($urandom_range(0, 1) == 1) wr_chk(a, $urandom(), 4'($urandom_range(0, 15)), resp);
            else rd_chk(a, rd);
        end

        // Rising edge on bit 0 raises IRQ_OUT exactly four cycles later
        wr_chk(32'h00, 32'h1, 4'hF, resp);
        wr_chk(32'h04, 32'h1, 4'hF, resp);
        wr_chk(32'h10, 32'h1, 4'hF, resp);
        wr_chk(32'h08, 32'hFF, 4'hF, resp);
        check("irq_idle", IRQ_OUT, 1'b0);
        GPIO_IN = 8'h01; m_in = 8'h01; m_stat = m_stat | 8'h01;
        repeat (3) @(posedge ACLK);
        #1;
        check("irq_lat3", IRQ_OUT, 1'b0);
        @(posedge ACLK); #1;
        check("irq_lat4", IRQ_OUT, 1'b1);
        rd_chk(32'h08, rd);
        check("stat_after_edge", rd, 32'h1);
        wr_chk(32'h08, 32'h1, 4'hF, resp);
        check("irq_cleared", IRQ_OUT, 1'b0);

        // Polarity change alone is silent; then event and W1C land on the same edge
        wr_chk(32'h10, 32'h0, 4'hF, resp);
        repeat (4) @(posedge ACLK);
        #1;
        rd_chk(32'h08, rd);
        check("edgesel_no_event", rd, 32'h0);
        GPIO_IN = 8'h00; m_in = 8'h00;
        @(posedge ACLK);
        @(posedge ACLK); #1;
        S_AWADDR = 32'h08; S_WDATA = 32'h1; S_WSTRB = 4'hF; S_AWVALID = 1'b1; S_WVALID = 1'b1;
        #1;
        check("setwins_awready", S_AWREADY, 1'b1);
        @(posedge ACLK); #1;
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        check("setwins_bvalid", S_BVALID, 1'b1);
        @(posedge ACLK); #1;
        m_stat = m_stat | 8'h01;
        rd_chk(32'h08, rd);
        check("setwins_stat", rd[0], 1'b1);
        wr_chk(32'h08, 32'hFF, 4'hF, resp);

        // Randomized GPIO activity with random polarity, enables and clears
        wr_chk(32'h04, $urandom(), 4'hF, resp);
        for (int i = 0; i < 30; i++) begin
            nw = 8'($urandom_range(0, 255));
            ev = (nw & ~m_in & m_edge) | (~nw & m_in & ~m_edge);
            @(posedge ACLK); #1;
            GPIO_IN = nw; m_in = nw; m_stat = m_stat | ev;
            repeat (4) @(posedge ACLK);
            #1;
            check("gpio_irq", IRQ_OUT, exp_irq());
            rd_chk(32'h0C, rd);
            rd_chk(32'h08, rd);
            case ($urandom_range(0, 3))
                0: wr_chk(32'h08, $urandom(), 4'($urandom_range(0, 15)), resp);
                1: wr_chk(32'h10, $urandom(), 4'hF, resp);
                2: wr_chk(32'h00, $urandom(), 4'hF, resp);
                default: ;
            endcase
        end

        // Back-pressure on B and R, then reset in the middle of it
        GPIO_IN = '0;
        repeat (4) @(posedge ACLK);
        #1;
        m_in = '0;
        wr_chk(32'h08, 32'hFF, 4'hF, resp);
        S_BREADY = 1'b0;
        hd = $urandom();
        resp = model_write(32'h24, hd, 4'hF);
        S_AWADDR = 32'h24; S_WDATA = hd; S_WSTRB = 4'hF; S_AWVALID = 1'b1; S_WVALID = 1'b1;
        #1;
        check("hold_awready", S_AWREADY, 1'b1);
        @(posedge ACLK); #1;
        S_AWADDR = 32'h20; S_WDATA = ~hd;
        for (int i = 0; i < 5; i++) begin
            check("hold_bvalid", S_BVALID, 1'b1);
            check("hold_bresp", S_BRESP, resp);
            check("hold_no_aw", S_AWREADY, 1'b0);
            @(posedge ACLK); #1;
        end
        check("hold_gpio_out", GPIO_OUT, {m_out[1], m_out[0]});
        S_RREADY = 1'b0;
        S_ARADDR = 32'h24; S_ARVALID = 1'b1;
        #1;
        check("hold_arready", S_ARREADY, 1'b1);
        @(posedge ACLK); #1;
        S_ARADDR = 32'h20;
        for (int i = 0; i < 5; i++) begin
            check("hold_rvalid", S_RVALID, 1'b1);
            check("hold_rdata", S_RDATA, {16'd0, m_out[1]});
            check("hold_no_ar", S_ARREADY, 1'b0);
            @(posedge ACLK); #1;
        end
        ARESETn = 1'b0;
        #1;
        model_reset();
        check("midrst_bvalid", S_BVALID, 1'b0);
        check("midrst_rvalid", S_RVALID, 1'b0);
        check("midrst_awready", S_AWREADY, 1'b0);
        check("midrst_gpio_out", GPIO_OUT, 32'h0);
        check("midrst_irq", IRQ_OUT, 1'b0);
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        S_BREADY = 1'b1; S_RREADY = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        check("post_rst_bvalid", S_BVALID, 1'b0);
        check("post_rst_rvalid", S_RVALID, 1'b0);
        rd_chk(32'h24, rd);
        rd_chk(32'h00, rd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
